// File: rtl/sim_ctrl_arbiter.sv
// Round-robin arbiter sharing the simulator-control device port among hosts.
// Routes responses back to the issuer and freezes grants after a halt write.
module sim_ctrl_arbiter #(
  parameter int         NumHosts       = 2,
  parameter logic [7:0] HaltAddrIdx    = 8'h2,
  parameter bit         BlockAfterHalt = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumHosts-1:0]      host_req_i,
  input  logic [NumHosts-1:0]      host_we_i,
  input  logic [4*NumHosts-1:0]    host_be_i,
  input  logic [32*NumHosts-1:0]   host_addr_i,
  input  logic [32*NumHosts-1:0]   host_wdata_i,
  output logic [NumHosts-1:0]      host_gnt_o,
  output logic [NumHosts-1:0]      host_rvalid_o,
  output logic [31:0]              host_rdata_o,
  output logic                     dev_req_o,
  output logic                     dev_we_o,
  output logic [3:0]               dev_be_o,
  output logic [31:0]              dev_addr_o,
  output logic [31:0]              dev_wdata_o,
  input  logic                     dev_rvalid_i,
  input  logic [31:0]              dev_rdata_i,
  output logic                     halted_o,
  output logic                     err_o
);

  typedef enum logic {RUN, HALTED} mode_e;

  mode_e      mode_q;
  logic [1:0] rr_q;
  logic [1:0] idx_q;
  logic       pend_q;
  logic       err_q;

  logic [3:0] req4;
  logic [1:0] win;
  logic [1:0] nxt;
  logic       allow;
  logic       gnt_any;
  logic       rsp_ok;
  logic       halt_wr;

  assign rsp_ok = pend_q & dev_rvalid_i;

  // Stall only while a response is owed and not arriving this cycle.
  assign allow = (mode_q == RUN || !BlockAfterHalt) &&
                 !(pend_q && !dev_rvalid_i);

  always_comb begin
    int j;
    j       = 0;
    req4    = '0;
    req4[NumHosts-1:0] = host_req_i;
    win     = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NumHosts; k++) begin
      j = int'(rr_q) + k;
      if (j >= NumHosts) j = j - NumHosts;
      if (!gnt_any && allow && req4[j[1:0]]) begin
        gnt_any = 1'b1;
        win     = j[1:0];
      end
    end
  end

  assign nxt = (win == 2'(NumHosts - 1)) ? 2'd0 : win + 2'd1;

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    dev_we_o      = 1'b0;
    dev_be_o      = '0;
    dev_addr_o    = '0;
    dev_wdata_o   = '0;
    for (int h = 0; h < NumHosts; h++) begin
      if (gnt_any && win == 2'(h)) begin
        host_gnt_o[h] = 1'b1;
        dev_we_o      = host_we_i[h];
        dev_be_o      = host_be_i[4*h +: 4];
        dev_addr_o    = host_addr_i[32*h +: 32];
        dev_wdata_o   = host_wdata_i[32*h +: 32];
      end
      host_rvalid_o[h] = rsp_ok && idx_q == 2'(h);
    end
  end

  assign dev_req_o    = gnt_any;
  assign host_rdata_o = rsp_ok ? dev_rdata_i : '0;

  assign halt_wr = gnt_any && dev_we_o && dev_be_o[0] &&
                   dev_wdata_o[0] &&
                   dev_addr_o[9:2] == HaltAddrIdx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= RUN;
      rr_q   <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (gnt_any) begin
        rr_q   <= nxt;
        idx_q  <= win;
        pend_q <= 1'b1;
        if (halt_wr) mode_q <= HALTED;
      end else if (dev_rvalid_i) begin
        pend_q <= 1'b0;
      end
      if (dev_rvalid_i && !pend_q) err_q <= 1'b1;
    end
  end

  assign halted_o = (mode_q == HALTED);
  assign err_o    = err_q;

endmodule
